traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised two-road intersection controller; next generation of the fixed 20-cycle, sensor-only north/east light block. Drives north (main) and east (side) signal heads. Adds configurable phase durations, an all-red clearance interval, side-road green extension up to a maximum, a latched pedestrian request with WALK output, and a flashing maintenance mode. Sits between the intersection sensor/button synchronisers and the lamp drivers.

## Interface
- TICK_DIV, 20: clock cycles per timing tick (≥2)
- GREEN_T, 8: minimum green, in ticks (≥1)
- YELLOW_T, 3: yellow duration, in ticks (≥1)
- ALLRED_T, 1: all-red clearance, in ticks (≥1)
- MAX_GREEN, 16: maximum east green under continuous demand, in ticks (≥GREEN_T)
- CNT_W, 8: width of prescaler and phase timer; TICK_DIV and all tick parameters < 2^CNT_W
- CLK  in  1  single clock, rising edge
- CLR_N  in  1  reset; asynchronous and active-low
- T  in  1  east-road car sensor, synchronous level
- PED  in  1  pedestrian button, synchronous; any 1-cycle pulse is a request
- FLASH  in  1  maintenance flash mode, synchronous level
- GN, YN, RN  out  1 each  north green/yellow/red
- GE, YE, RE  out  1 each  east green/yellow/red
- WALK  out  1  pedestrian walk signal (crossing the north road)

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where prescaler==TICK_DIV-1. Free-running in all states, including FLASH.
- Phase timer is cleared to 0 on every state change. Otherwise it increments on tick. It saturates at 2^CNT_W-1.
- ped_pend sets on any cycle with PED=1. It clears on the edge entering EW_GRN. If PED=1 on that same edge, ped_pend stays set (set wins).
- States and transitions. All non-FLASH transitions occur only on an edge with tick=1:
  - NS_GRN: GN, RE. Go to NS_YEL when timer≥GREEN_T-1 and (T or ped_pend). Otherwise hold indefinitely.
  - NS_YEL: YN, RE. Go to AR1 when timer==YELLOW_T-1.
  - AR1: RN, RE. Go to EW_GRN when timer==ALLRED_T-1. On this edge, walk_act is loaded with ped_pend.
  - EW_GRN: RN, GE; WALK=walk_act. Go to EW_YEL when timer≥GREEN_T-1 and (T==0 or timer==MAX_GREEN-1).
  - EW_YEL: RN, YE. Go to AR2 when timer==YELLOW_T-1. walk_act clears on entry.
  - AR2: RN, RE. Go to NS_GRN when timer==ALLRED_T-1.
  - FLASH: GN=GE=YE=RN=WALK=0. YN=RE=flash_ph. flash_ph toggles on each tick.
- FLASH=1 in any state forces FLASH on the next edge, regardless of tick. Entering FLASH sets flash_ph=1 and clears walk_act. ped_pend is retained.
- FLASH=0 while in FLASH goes to AR2 on the next edge, with timer=0. The normal sequence then resumes.
- Outputs are Moore-decoded from state, walk_act and flash_ph. Exactly one lamp per head is lit, except in FLASH.
- Never GN and GE together. Never a green without an intervening yellow and all-red.

## Timing
- Reset (CLR_N=0) applies immediately, with no clock needed:
  - state=NS_GRN, prescaler=0, timer=0, ped_pend=0, walk_act=0, flash_ph=0
  - outputs GN=1, RE=1, all others 0
- After reset release, the first tick is the TICK_DIV-th rising edge.
- A state of N ticks lasts exactly N×TICK_DIV cycles when entered on a tick edge. Defaults: green min 160, yellow 60, all-red 20, east max 320 cycles.
- T is sampled only on tick edges. Changes between ticks have no effect.
- Reset asserted mid-phase aborts to the reset state immediately. No yellow or all-red is produced.

## Test plan
- Reset, T=0, PED=0, FLASH=0 for 1000 cycles -> GN=1 and RE=1 constantly; no transition.
- Reset, T=1 held:
  - GN low at cycle 160
  - YN cycles 160–219
  - all-red 220–239
  - GE 240–559 (MAX_GREEN cap)
  - YE 560–619
  - all-red 620–639
  - GN again at 640
- T=0, single PED pulse at cycle 50 -> NS_YEL at 160 -> EW_GRN at 240 with WALK=1 for 160 cycles. WALK=0 from EW_YEL onward; ped_pend cleared.
- T pulse high only across the tick at cycle 159 -> EW_GRN lasts exactly GREEN_T ticks (160 cycles).
- FLASH raised during EW_GRN -> next edge: GE=0, YN=RE=1, both toggling every 20 cycles. FLASH dropped -> AR2 for 20 cycles (tick-aligned), then NS_GRN.
- CLR_N pulsed low asynchronously during NS_YEL -> outputs return to GN=1, RE=1 without a clock edge; a PED pulse before reset does not survive.

Source files
------------

// File: rtl/traffic_ctrl_param_if.sv
// Signal bundle between the intersection controller and its environment:
// sensor/button inputs toward the controller, lamp and WALK outputs back.
interface traffic_ctrl_param_if;
  logic T;
  logic PED;
  logic FLASH;
  logic GN, YN, RN;
  logic GE, YE, RE;
  logic WALK;

  modport master (
    output T, PED, FLASH,
    input  GN, YN, RN, GE, YE, RE, WALK
  );

  modport slave (
    input  T, PED, FLASH,
    output GN, YN, RN, GE, YE, RE, WALK
  );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Two-road (north main / east side) signal controller with tick-based phase
// timing, all-red clearance, east green extension, latched WALK and flash mode.
module traffic_ctrl_param #(
  parameter int TICK_DIV  = 20,
  parameter int GREEN_T   = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int MAX_GREEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  traffic_ctrl_param_if.slave   bus
);

  typedef enum logic [2:0] {
    S_NS_GRN, S_NS_YEL, S_AR1, S_EW_GRN, S_EW_YEL, S_AR2, S_FLASH
  } state_t;

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, timer_q;
  logic             tick, state_chg;
  logic             ped_pend_q, walk_act_q, flash_ph_q;
  logic             enter_ew_grn, leave_ew_grn;

  assign tick         = (presc_q == DIV_LAST);
  assign state_chg    = (state_d != state_q);
  assign enter_ew_grn = (state_q == S_AR1) && (state_d == S_EW_GRN);
  assign leave_ew_grn = (state_q == S_EW_GRN) && (state_d == S_EW_YEL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) presc_q <= '0;
    else        presc_q <= tick ? '0 : presc_q + ONE;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state_q <= S_NS_GRN;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NS_GRN: if (tick && timer_q >= GREEN_LAST && (bus.T || ped_pend_q))
                  state_d = S_NS_YEL;
      S_NS_YEL: if (tick && timer_q == YELLOW_LAST) state_d = S_AR1;
      S_AR1:    if (tick && timer_q == ALLRED_LAST) state_d = S_EW_GRN;
      S_EW_GRN: if (tick && timer_q >= GREEN_LAST && (!bus.T || timer_q == MAX_LAST))
                  state_d = S_EW_YEL;
      S_EW_YEL: if (tick && timer_q == YELLOW_LAST) state_d = S_AR2;
      S_AR2:    if (tick && timer_q == ALLRED_LAST) state_d = S_NS_GRN;
      S_FLASH:  state_d = S_AR2;
      default:  state_d = S_NS_GRN;
    endcase
    // Flash mode overrides everything and is not tick-gated.
    if (bus.FLASH) state_d = S_FLASH;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)                     timer_q <= '0;
    else if (state_chg)             timer_q <= '0;
    else if (tick && timer_q != '1) timer_q <= timer_q + ONE;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ped_pend_q <= 1'b0;
      walk_act_q <= 1'b0;
      flash_ph_q <= 1'b0;
    end else begin
      if (bus.PED)           ped_pend_q <= 1'b1;
      else if (enter_ew_grn) ped_pend_q <= 1'b0;

      if (state_d == S_FLASH)  walk_act_q <= 1'b0;
      else if (enter_ew_grn)   walk_act_q <= ped_pend_q;
      else if (leave_ew_grn)   walk_act_q <= 1'b0;

      // Phase restarts lit on entry so the flash is visible immediately.
      if (state_d == S_FLASH) begin
        if (state_q != S_FLASH) flash_ph_q <= 1'b1;
        else if (tick)          flash_ph_q <= ~flash_ph_q;
      end
    end
  end

  logic gn, yn, rn, ge, ye, re, walk;

  always_comb begin
    {gn, yn, rn, ge, ye, re, walk} = '0;
    case (state_q)
      S_NS_GRN: begin gn = 1'b1; re = 1'b1; end
      S_NS_YEL: begin yn = 1'b1; re = 1'b1; end
      S_EW_GRN: begin rn = 1'b1; ge = 1'b1; walk = walk_act_q; end
      S_EW_YEL: begin rn = 1'b1; ye = 1'b1; end
      S_FLASH:  begin yn = flash_ph_q; re = flash_ph_q; end
      default:  begin rn = 1'b1; re = 1'b1; end
    endcase
  end

  assign bus.GN   = gn;
  assign bus.YN   = yn;
  assign bus.RN   = rn;
  assign bus.GE   = ge;
  assign bus.YE   = ye;
  assign bus.RE   = re;
  assign bus.WALK = walk;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param at default parameters (20-cycle tick).
module tb_traffic_ctrl_param;

  // Lamp vector order: {GN, YN, RN, GE, YE, RE, WALK}
  localparam logic [6:0] L_NSG  = 7'b1000010;
  localparam logic [6:0] L_NSY  = 7'b0100010;
  localparam logic [6:0] L_AR   = 7'b0010010;
  localparam logic [6:0] L_EWG  = 7'b0011000;
  localparam logic [6:0] L_EWGW = 7'b0011001;
  localparam logic [6:0] L_EWY  = 7'b0010100;
  localparam logic [6:0] L_FLON = 7'b0100010;
  localparam logic [6:0] L_FLOF = 7'b0000000;

  logic CLK;
  logic CLR_N;
  int   cyc;
  int   n_pass;
  int   n_fail;

  traffic_ctrl_param_if bus ();

  traffic_ctrl_param dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .bus   (bus.slave)
  );

  logic [6:0] lamps;
  assign lamps = {bus.GN, bus.YN, bus.RN, bus.GE, bus.YE, bus.RE, bus.WALK};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [6:0] exp);
    assert (lamps === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, lamps, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge k (edges counted from reset release).
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge CLK);
      cyc++;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR_N = 1'b0;
    #1;
    check("in_reset", L_NSG);
    @(negedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    n_pass    = 0;
    n_fail    = 0;
    cyc       = 0;
    CLR_N     = 1'b0;
    bus.T     = 1'b0;
    bus.PED   = 1'b0;
    bus.FLASH = 1'b0;
    #2;
    check("reset_no_clock", L_NSG);

    // Idle: no demand, north green forever.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      go_to(i * 100);
      check("idle_hold", L_NSG);
    end

    // Continuous east demand: full cycle with MAX_GREEN cap.
    do_reset();
    bus.T = 1'b1;
    go_to(159); check("t_nsg_end",  L_NSG);
    go_to(160); check("t_nsy_beg",  L_NSY);
    go_to(219); check("t_nsy_end",  L_NSY);
    go_to(220); check("t_ar1_beg",  L_AR);
    go_to(239); check("t_ar1_end",  L_AR);
    go_to(240); check("t_ewg_beg",  L_EWG);
    go_to(559); check("t_ewg_max",  L_EWG);
    go_to(560); check("t_ewy_beg",  L_EWY);
    go_to(619); check("t_ewy_end",  L_EWY);
    go_to(620); check("t_ar2_beg",  L_AR);
    go_to(639); check("t_ar2_end",  L_AR);
    go_to(640); check("t_nsg_again", L_NSG);
    bus.T = 1'b0;

    // Single pedestrian pulse at cycle 50.
    do_reset();
    go_to(49);  bus.PED = 1'b1;
    go_to(50);  bus.PED = 1'b0;
    go_to(159); check("p_nsg_end",  L_NSG);
    go_to(160); check("p_nsy_beg",  L_NSY);
    go_to(240); check("p_walk_beg", L_EWGW);
    go_to(399); check("p_walk_end", L_EWGW);
    go_to(400); check("p_ewy_nowalk", L_EWY);
    go_to(460); check("p_ar2",      L_AR);
    go_to(480); check("p_nsg",      L_NSG);
    go_to(700); check("p_pend_clr", L_NSG);
    // T pulse between tick edges is never sampled.
    bus.T = 1'b1;
    go_to(710); bus.T = 1'b0;
    go_to(740); check("t_between_ticks", L_NSG);

    // T high only across the tick edge at 160: minimum east green.
    do_reset();
    go_to(159); bus.T = 1'b1;
    go_to(160); bus.T = 1'b0;
    check("tp_nsy",     L_NSY);
    go_to(240); check("tp_ewg_beg", L_EWG);
    go_to(399); check("tp_ewg_end", L_EWG);
    go_to(400); check("tp_ewy",     L_EWY);

    // Flash raised during east green, dropped on a tick edge.
    do_reset();
    bus.T = 1'b1;
    go_to(300); check("f_ewg",     L_EWG);
    bus.FLASH = 1'b1;
    go_to(301); check("f_on_entry", L_FLON);
    go_to(319); check("f_on_hold",  L_FLON);
    go_to(320); check("f_off",      L_FLOF);
    go_to(339); check("f_off_hold", L_FLOF);
    go_to(340); check("f_on_again", L_FLON);
    go_to(379); bus.FLASH = 1'b0;
    go_to(380); check("f_ar2_beg", L_AR);
    go_to(399); check("f_ar2_end", L_AR);
    go_to(400); check("f_nsg",     L_NSG);
    bus.T = 1'b0;

    // Asynchronous reset mid NS_YEL drops the pending pedestrian request.
    do_reset();
    go_to(49);  bus.PED = 1'b1;
    go_to(50);  bus.PED = 1'b0;
    go_to(170); check("r_nsy", L_NSY);
    #2;
    CLR_N = 1'b0;
    #1;
    check("r_async", L_NSG);
    @(negedge CLK);
    CLR_N = 1'b1;
    cyc   = 0;
    go_to(200); check("r_no_ped", L_NSG);
    go_to(400); check("r_no_ped_late", L_NSG);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
